// File: rtl/if_fetch_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : if_fetch_pkg
//  Description : Shared types and constants for the instruction-fetch stage:
//                address/instruction bus types, zero/NOP words, reset level,
//                the {pc,inst} buffer entry and a word-alignment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_fetch_pkg;

    typedef logic [31:0] inst_addr_t;
    typedef logic [31:0] inst_t;

    localparam inst_addr_t c_zero_word  = 32'h0000_0000;
    localparam inst_t      c_nop_word   = 32'h0000_0000;
    localparam logic       c_rst_enable = 1'b1;

    typedef struct packed {
        inst_addr_t pc;
        inst_t      inst;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; low byte-offset bits are dropped.
    function automatic inst_addr_t word_align(input inst_addr_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : if_fetch_fifo
//  Description : DEPTH-entry buffer of {pc,inst} pairs between instruction
//                memory and decode. Push/pop/clear, occupancy count and
//                full/empty flags. Head reads as zeros when empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_fifo
    import if_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [31:0]            push_pc_i,
    input  logic [31:0]            push_inst_i,
    output logic [31:0]            head_pc_o,
    output logic [31:0]            head_inst_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] c_ptr_one = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   c_cnt_one = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   c_cnt_max = (PTR_W+1)'(DEPTH);

    fetch_entry_t         mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [PTR_W:0]       count_q;
    logic                 do_push;
    logic                 do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == c_cnt_max);
    assign count_o = count_q;

    // Pop on empty is ignored; a push on full is only taken when a pop frees the slot.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign head_pc_o   = empty_o ? c_zero_word : mem_q[rd_ptr_q].pc;
    assign head_inst_o = empty_o ? c_nop_word  : mem_q[rd_ptr_q].inst;

    // Entry storage: data only, validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push && !clear_i) begin
            mem_q[wr_ptr_q] <= '{pc: push_pc_i, inst: push_inst_i};
        end
    end

    // Pointer and occupancy bookkeeping; clear wins over push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == c_rst_enable) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + c_ptr_one;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + c_ptr_one;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + c_cnt_one;
                2'b01:   count_q <= count_q - c_cnt_one;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/if_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : if_fetch
//  Description : Instruction-fetch stage. Owns the fetch PC, issues one word
//                request at a time over req/ack, buffers returned words and
//                presents them to decode. Redirects flush everything in
//                flight and restart at the new PC.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] c_depth   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DROP = 2'b10
    } fetch_state_e;

    fetch_state_e     state_q, state_d;
    inst_addr_t       fpc_q, fpc_d;
    inst_addr_t       drop_addr_q, drop_addr_d;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] count_after_push;

    assign pop              = !fifo_empty && !stall_i && !redirect_i;
    assign count_after_push = fifo_count + c_cnt_one - CNT_W'(pop);

    assign imem_req_o  = (state_q == ST_REQ) || (state_q == ST_DROP);
    // In DROP the abandoned request must stay stable until memory acks it.
    assign imem_addr_o = (state_q == ST_DROP) ? drop_addr_q : fpc_q;
    assign valid_o     = !fifo_empty;

    // Next-state, next-PC and push decision.
    always_comb begin
        state_d     = state_q;
        fpc_d       = fpc_q;
        drop_addr_d = drop_addr_q;
        push        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (redirect_i) begin
                    fpc_d   = word_align(redirect_pc_i);
                    state_d = ST_REQ;
                end else if (!fifo_full) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (redirect_i) begin
                    fpc_d = word_align(redirect_pc_i);
                    if (imem_ack_i) begin
                        state_d = ST_REQ;
                    end else begin
                        drop_addr_d = fpc_q;
                        state_d     = ST_DROP;
                    end
                end else if (imem_ack_i) begin
                    push    = 1'b1;
                    fpc_d   = fpc_q + 32'd4;
                    state_d = (count_after_push < c_depth) ? ST_REQ : ST_IDLE;
                end
            end
            ST_DROP: begin
                if (redirect_i) begin
                    fpc_d = word_align(redirect_pc_i);
                end
                if (imem_ack_i) begin
                    state_d = (redirect_i || !fifo_full) ? ST_REQ : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and fetch-PC registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == c_rst_enable) begin
            state_q     <= ST_IDLE;
            fpc_q       <= RESET_PC;
            drop_addr_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            fpc_q       <= fpc_d;
            drop_addr_q <= drop_addr_d;
        end
    end

    if_fetch_fifo #(
        .DEPTH       (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (redirect_i),
        .push_i      (push),
        .pop_i       (pop),
        .push_pc_i   (fpc_q),
        .push_inst_i (imem_data_i),
        .head_pc_o   (pc_o),
        .head_inst_o (inst_o),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch
//  Description : Self-checking bench for if_fetch: per-cycle vector table for
//                streaming/stall/redirect, plus hand sequences for slow
//                memory, DROP handling, same-cycle redirect+ack and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;

    // Memory responder (auto) or manually driven ack/data.
    logic        auto_mode;
    int          lat;
    logic        r_ack;
    logic [31:0] r_data;
    logic        m_ack;
    logic [31:0] m_data;

    assign imem_ack_i  = auto_mode ? r_ack  : m_ack;
    assign imem_data_i = auto_mode ? r_data : m_data;

    int n_tests;
    int n_fail;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_req;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vt[20];

    if_fetch #(
        .RESET_PC      (32'h0000_0000),
        .FIFO_DEPTH    (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_data_i   (imem_data_i),
        .valid_o       (valid_o),
        .pc_o          (pc_o),
        .inst_o        (inst_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'hC0DE_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic set_v(input int i, input logic s, input logic r, input logic [31:0] rpc,
                         input logic v, input logic [31:0] pc, input logic q, input logic [31:0] a);
        vt[i] = '{stall: s, redir: r, rpc: rpc, e_valid: v, e_pc: pc, e_req: q, e_addr: a};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Responder: acks a pending request once it has waited 'lat' cycles.
    initial begin
        int cnt;
        cnt    = 0;
        r_ack  = 1'b0;
        r_data = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            if (imem_req_o && cnt >= lat) begin
                r_ack  = 1'b1;
                r_data = mem_word(imem_addr_o);
                cnt    = 0;
            end else begin
                r_ack = 1'b0;
                cnt   = imem_req_o ? cnt + 1 : 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b1;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        auto_mode     = 1'b1;
        lat           = 0;
        m_ack         = 1'b0;
        m_data        = 32'h0;

        // Streaming, stall/drain, and redirect with a full buffer.
        set_v( 0, 0, 0, 32'h0,   0, 32'h00,  1, 32'h00);
        set_v( 1, 0, 0, 32'h0,   1, 32'h00,  1, 32'h04);
        set_v( 2, 0, 0, 32'h0,   1, 32'h04,  1, 32'h08);
        set_v( 3, 0, 0, 32'h0,   1, 32'h08,  1, 32'h0C);
        set_v( 4, 1, 0, 32'h0,   1, 32'h0C,  1, 32'h10);
        set_v( 5, 1, 0, 32'h0,   1, 32'h0C,  0, 32'h14);
        set_v( 6, 1, 0, 32'h0,   1, 32'h0C,  0, 32'h14);
        set_v( 7, 1, 0, 32'h0,   1, 32'h0C,  0, 32'h14);
        set_v( 8, 1, 0, 32'h0,   1, 32'h0C,  0, 32'h14);
        set_v( 9, 1, 0, 32'h0,   1, 32'h0C,  0, 32'h14);
        set_v(10, 0, 0, 32'h0,   1, 32'h0C,  0, 32'h14);
        set_v(11, 0, 0, 32'h0,   1, 32'h10,  0, 32'h14);
        set_v(12, 0, 0, 32'h0,   0, 32'h00,  1, 32'h14);
        set_v(13, 0, 0, 32'h0,   1, 32'h14,  1, 32'h18);
        set_v(14, 0, 0, 32'h0,   1, 32'h18,  1, 32'h1C);
        set_v(15, 1, 0, 32'h0,   1, 32'h1C,  1, 32'h20);
        set_v(16, 1, 1, 32'h103, 1, 32'h1C,  0, 32'h24);
        set_v(17, 0, 0, 32'h0,   0, 32'h00,  1, 32'h100);
        set_v(18, 0, 0, 32'h0,   1, 32'h100, 1, 32'h104);
        set_v(19, 0, 0, 32'h0,   1, 32'h104, 1, 32'h108);

        // Reset state, observed while reset is held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("reset req",   imem_req_o,  1'b0);
        chk ("reset addr",  imem_addr_o, 32'h0);
        chk1("reset valid", valid_o,     1'b0);
        chk ("reset pc",    pc_o,        32'h0);
        chk ("reset inst",  inst_o,      32'h0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            stall_i       = vt[i].stall;
            redirect_i    = vt[i].redir;
            redirect_pc_i = vt[i].rpc;
            @(negedge clk);
            chk1($sformatf("vec%0d valid", i), valid_o,     vt[i].e_valid);
            chk ($sformatf("vec%0d pc",    i), pc_o,        vt[i].e_pc);
            chk ($sformatf("vec%0d inst",  i), inst_o,      vt[i].e_valid ? mem_word(vt[i].e_pc) : 32'h0);
            chk1($sformatf("vec%0d req",   i), imem_req_o,  vt[i].e_req);
            chk ($sformatf("vec%0d addr",  i), imem_addr_o, vt[i].e_addr);
        end
        @(posedge clk);
        #1;
        stall_i    = 1'b0;
        redirect_i = 1'b0;

        // Slow memory: three wait cycles per word.
        begin
            logic [31:0] exp_addr;
            logic [31:0] exp_pc;
            int          ndrain;
            int          gaps;
            exp_addr = 32'h0;
            exp_pc   = 32'h0;
            ndrain   = 0;
            gaps     = 0;
            lat      = 3;
            do_reset();
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                if (imem_req_o) begin
                    chk($sformatf("slow addr c%0d", c), imem_addr_o, exp_addr);
                    if (imem_ack_i) exp_addr = exp_addr + 32'd4;
                end
                if (valid_o) begin
                    chk($sformatf("slow pc c%0d", c),   pc_o,   exp_pc);
                    chk($sformatf("slow inst c%0d", c), inst_o, mem_word(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                    ndrain++;
                end else begin
                    gaps++;
                end
            end
            chk("slow words drained", 32'(ndrain), 32'd7);
            chk("slow valid gaps",    32'(gaps),   32'd23);
            lat = 0;
        end

        // Redirect while waiting (DROP), second redirect in DROP, same-cycle redirect+ack.
        auto_mode = 1'b0;
        m_ack     = 1'b0;
        do_reset();
        @(posedge clk); #1;
        @(negedge clk);
        chk1("drop c0 req",  imem_req_o,  1'b1);
        chk ("drop c0 addr", imem_addr_o, 32'h0);
        @(posedge clk); #1;
        redirect_i = 1'b1; redirect_pc_i = 32'h200;
        @(negedge clk);
        chk ("drop c1 addr", imem_addr_o, 32'h0);
        @(posedge clk); #1;
        redirect_i = 1'b1; redirect_pc_i = 32'h300;
        @(negedge clk);
        chk1("drop c2 req",   imem_req_o,  1'b1);
        chk ("drop c2 addr",  imem_addr_o, 32'h0);
        chk1("drop c2 valid", valid_o,     1'b0);
        @(posedge clk); #1;
        redirect_i = 1'b0; m_ack = 1'b1; m_data = 32'hDEAD_BEEF;
        @(negedge clk);
        chk ("drop c3 addr", imem_addr_o, 32'h0);
        @(posedge clk); #1;
        m_ack = 1'b1; m_data = mem_word(32'h300);
        @(negedge clk);
        chk1("drop c4 valid", valid_o,     1'b0);
        chk1("drop c4 req",   imem_req_o,  1'b1);
        chk ("drop c4 addr",  imem_addr_o, 32'h300);
        @(posedge clk); #1;
        redirect_i = 1'b1; redirect_pc_i = 32'h400; m_ack = 1'b1; m_data = 32'h1234_5678;
        @(negedge clk);
        chk1("drop c5 valid", valid_o,     1'b1);
        chk ("drop c5 pc",    pc_o,        32'h300);
        chk ("drop c5 inst",  inst_o,      mem_word(32'h300));
        chk ("drop c5 addr",  imem_addr_o, 32'h304);
        @(posedge clk); #1;
        redirect_i = 1'b0; m_ack = 1'b0;
        @(negedge clk);
        chk1("redir+ack valid", valid_o,     1'b0);
        chk1("redir+ack req",   imem_req_o,  1'b1);
        chk ("redir+ack addr",  imem_addr_o, 32'h400);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("redir+ack later valid", valid_o,     1'b0);
        chk ("redir+ack later addr",  imem_addr_o, 32'h400);

        // Asynchronous reset in the middle of a request.
        #2;
        rst = 1'b1;
        #1;
        chk1("async rst req",   imem_req_o,  1'b0);
        chk ("async rst addr",  imem_addr_o, 32'h0);
        chk1("async rst valid", valid_o,     1'b0);
        chk ("async rst pc",    pc_o,        32'h0);
        chk ("async rst inst",  inst_o,      32'h0);
        m_ack  = 1'b1;
        m_data = mem_word(32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk1("late ack valid", valid_o,     1'b0);
        chk1("late ack req",   imem_req_o,  1'b1);
        chk ("late ack addr",  imem_addr_o, 32'h0);
        @(posedge clk); #1;
        m_ack = 1'b0;
        @(negedge clk);
        chk1("post rst valid", valid_o, 1'b1);
        chk ("post rst pc",    pc_o,    32'h0);
        chk ("post rst inst",  inst_o,  mem_word(32'h0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
